// File: rtl/ir_queue_pkg.sv
// ir_queue_pkg: lc3b word and field types shared by the instruction queue and its decoder
package ir_queue_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [5:0]  lc3b_offset6;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [10:0] lc3b_offset11;
endpackage

// File: rtl/ir_queue_if.sv
// ir_queue_if: fetch push handshake, control dequeue strobe and head decode fields
interface ir_queue_if #(parameter int DEPTH = 4);
  import ir_queue_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  logic         flush;
  lc3b_word     in;
  logic         in_valid;
  logic         in_ready;
  logic         deq;
  logic         out_valid;
  lc3b_opcode   opcode;
  lc3b_reg      dest;
  lc3b_reg      src1;
  lc3b_reg      src2;
  lc3b_offset6  offset6;
  lc3b_offset9  offset9;
  lc3b_offset11 offset11;
  logic         imm5_enable;
  logic         imm11_enable;
  logic [CW-1:0] count;
  modport master (
    output flush, in, in_valid, deq,
    input  in_ready, out_valid, opcode, dest, src1, src2, offset6, offset9, offset11,
           imm5_enable, imm11_enable, count
  );
  modport slave (
    input  flush, in, in_valid, deq,
    output in_ready, out_valid, opcode, dest, src1, src2, offset6, offset9, offset11,
           imm5_enable, imm11_enable, count
  );
endinterface

// File: rtl/ir_queue_decode.sv
// ir_decode: splits a raw lc3b word into its opcode, register and offset fields
module ir_decode
  import ir_queue_pkg::*;
(
  input  lc3b_word     word,
  output lc3b_opcode   opcode,
  output lc3b_reg      dest,
  output lc3b_reg      src1,
  output lc3b_reg      src2,
  output lc3b_offset6  offset6,
  output lc3b_offset9  offset9,
  output lc3b_offset11 offset11,
  output logic         imm5_enable,
  output logic         imm11_enable
);
  assign opcode       = word[15:12];
  assign dest         = word[11:9];
  assign src1         = word[8:6];
  assign src2         = word[2:0];
  assign offset6      = word[5:0];
  assign offset9      = word[8:0];
  assign offset11     = word[10:0];
  assign imm5_enable  = word[5];
  assign imm11_enable = word[11];
endmodule

// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction FIFO between fetch and control, decoding its head entry
module ir_queue
  import ir_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  ir_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  lc3b_word mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign q.in_ready  = cnt < CW'(DEPTH);
  assign q.out_valid = cnt != '0;
  assign q.count     = cnt;
  assign push = q.in_valid && q.in_ready;
  assign pop  = q.deq && q.out_valid;
  // flush drops the same-cycle push and pop but leaves storage contents intact
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= q.in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  ir_decode u_dec (
    .word         (mem[rd_ptr]),
    .opcode       (q.opcode),
    .dest         (q.dest),
    .src1         (q.src1),
    .src2         (q.src2),
    .offset6      (q.offset6),
    .offset9      (q.offset9),
    .offset11     (q.offset11),
    .imm5_enable  (q.imm5_enable),
    .imm11_enable (q.imm11_enable)
  );
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed stimulus against a queue-based reference model of the instruction FIFO
module tb_ir_queue;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int errs = 0;
  logic [15:0] mq [$];
  logic [15:0] h;
  logic [15:0] seq [12];
  ir_queue_if #(.DEPTH(DEPTH)) qi ();
  ir_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .q(qi));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input logic v, input logic [15:0] w, input logic d, input logic f);
    qi.in_valid = v;
    qi.in = w;
    qi.deq = d;
    qi.flush = f;
    @(posedge clk);
    #1;
  endtask
  task automatic head(input string n, input logic [15:0] w);
    chk({n, " valid"}, int'(qi.out_valid), 1);
    chk({n, " word"}, int'({qi.opcode, qi.imm11_enable, qi.offset11}), int'(w));
  endtask
  task automatic idle_lits(input string n);
    chk({n, " out_valid"}, int'(qi.out_valid), 0);
    chk({n, " in_ready"}, int'(qi.in_ready), 1);
    chk({n, " count"}, int'(qi.count), 0);
    chk({n, " opcode"}, int'(qi.opcode), 0);
    chk({n, " offset11"}, int'(qi.offset11), 0);
    chk({n, " dest"}, int'(qi.dest), 0);
  endtask
  // reference model: plain queue, pops the front and appends accepted words
  always @(posedge clk or posedge reset)
    if (reset || qi.flush) mq.delete();
    else begin
      automatic bit pu = qi.in_valid && mq.size() < DEPTH;
      automatic bit po = qi.deq && mq.size() > 0;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(qi.in);
    end
  always @(negedge clk) begin
    chk("count", int'(qi.count), mq.size());
    chk("in_ready", int'(qi.in_ready), int'(mq.size() < DEPTH));
    chk("out_valid", int'(qi.out_valid), int'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      chk("opcode", int'(qi.opcode), int'(h[15:12]));
      chk("dest", int'(qi.dest), int'(h[11:9]));
      chk("src1", int'(qi.src1), int'(h[8:6]));
      chk("src2", int'(qi.src2), int'(h[2:0]));
      chk("offset6", int'(qi.offset6), int'(h[5:0]));
      chk("offset9", int'(qi.offset9), int'(h[8:0]));
      chk("offset11", int'(qi.offset11), int'(h[10:0]));
      chk("imm5", int'(qi.imm5_enable), int'(h[5]));
      chk("imm11", int'(qi.imm11_enable), int'(h[11]));
    end
  end
  initial begin
    qi.in_valid = 0;
    qi.in = '0;
    qi.deq = 0;
    qi.flush = 0;
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    idle_lits("reset");
    cyc(1, 16'h1242, 0, 0);
    cyc(1, 16'h5A3F, 0, 0);
    cyc(1, 16'hE1FF, 0, 0);
    cyc(1, 16'h0403, 0, 0);
    chk("full count", int'(qi.count), 4);
    chk("full in_ready", int'(qi.in_ready), 0);
    cyc(1, 16'hDEAD, 0, 0);
    chk("rejected count", int'(qi.count), 4);
    qi.in_valid = 0;
    head("e0", 16'h1242);
    chk("e0 opcode", int'(qi.opcode), 1);
    chk("e0 dest", int'(qi.dest), 1);
    chk("e0 src1", int'(qi.src1), 1);
    chk("e0 src2", int'(qi.src2), 2);
    chk("e0 imm5", int'(qi.imm5_enable), 0);
    cyc(0, 16'h0, 1, 0);
    head("e1", 16'h5A3F);
    chk("e1 opcode", int'(qi.opcode), 5);
    chk("e1 imm5", int'(qi.imm5_enable), 1);
    chk("e1 offset6", int'(qi.offset6), 6'h3F);
    cyc(0, 16'h0, 1, 0);
    head("e2", 16'hE1FF);
    chk("e2 opcode", int'(qi.opcode), 4'hE);
    cyc(0, 16'h0, 1, 0);
    head("e3", 16'h0403);
    chk("e3 src2", int'(qi.src2), 3);
    cyc(0, 16'h0, 1, 0);
    chk("drained out_valid", int'(qi.out_valid), 0);
    seq[0] = 16'hA001;
    seq[1] = 16'hA002;
    for (int k = 0; k < 10; k++) seq[k+2] = 16'h3000 + 16'(k);
    cyc(1, seq[0], 0, 0);
    cyc(1, seq[1], 0, 0);
    for (int k = 0; k < 10; k++) begin
      head("stream", seq[k]);
      cyc(1, seq[k+2], 1, 0);
      chk("stream count", int'(qi.count), 2);
    end
    cyc(1, 16'h7777, 0, 0);
    chk("pre-flush count", int'(qi.count), 3);
    cyc(1, 16'hFFFF, 1, 1);
    chk("flush count", int'(qi.count), 0);
    chk("flush out_valid", int'(qi.out_valid), 0);
    cyc(1, 16'h1111, 0, 0);
    head("post-flush", 16'h1111);
    chk("post-flush count", int'(qi.count), 1);
    cyc(0, 16'h0, 1, 0);
    repeat (3) begin
      cyc(0, 16'h0, 1, 0);
      chk("empty deq count", int'(qi.count), 0);
    end
    cyc(1, 16'hB7C5, 0, 0);
    head("after empty deq", 16'hB7C5);
    chk("b7c5 opcode", int'(qi.opcode), 4'hB);
    chk("b7c5 dest", int'(qi.dest), 3);
    cyc(1, 16'h4101, 0, 0);
    cyc(1, 16'h4102, 0, 0);
    qi.in_valid = 0;
    chk("pre-reset count", int'(qi.count), 3);
    #2 reset = 1;
    #1;
    idle_lits("async reset");
    @(posedge clk);
    @(posedge clk);
    #3 reset = 0;
    @(posedge clk);
    #1;
    cyc(1, 16'h2345, 0, 0);
    head("post-reset", 16'h2345);
    chk("post-reset count", int'(qi.count), 1);
    cyc(0, 16'h0, 1, 0);
    chk("post-reset drain", int'(qi.out_valid), 0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register that replaces the single-entry IR with a DEPTH-entry FIFO of fetched lc3b words. The fetch side pushes with a valid/ready handshake, and the control side consumes with a dequeue strobe. The head entry is decoded into opcode, register and offset fields. The block sits between the memory-data path and the control FSM/datapath, and lets fetch run ahead of execute.

## Interface
Parameters:
- DEPTH, default 4, number of instruction entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous discard of all entries (branch/redirect).
- in  in  16 (lc3b_word)  instruction word from fetch.
- in_valid  in  1  fetch presents a word on `in`.
- in_ready  out  1  queue can accept a word this cycle.
- deq  in  1  control consumes the head entry.
- out_valid  out  1  head entry holds a valid instruction.
- opcode  out  4 (lc3b_opcode)  head bits [15:12].
- dest  out  3 (lc3b_reg)  head bits [11:9].
- src1  out  3 (lc3b_reg)  head bits [8:6].
- src2  out  3 (lc3b_reg)  head bits [2:0].
- offset6  out  6 (lc3b_offset6)  head bits [5:0].
- offset9  out  9 (lc3b_offset9)  head bits [8:0].
- offset11  out  11 (lc3b_offset11)  head bits [10:0].
- imm5_enable  out  1  head bit [5].
- imm11_enable  out  1  head bit [11].
- count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Storage: DEPTH × lc3b_word array, with read pointer rd_ptr and write pointer wr_ptr (each $clog2(DEPTH) bits, wrapping modulo DEPTH), plus count.
- Enqueue fires when in_valid && in_ready: mem[wr_ptr] ← in, then wr_ptr++.
- Dequeue fires when deq && out_valid: rd_ptr++.
- Dequeue on an empty queue is ignored; no pointer or count change.
- Count update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both fire in the same cycle.
- in_ready = (count < DEPTH). Full is not relieved by a same-cycle deq; no pass-through on full.
- out_valid = (count != 0).
- Decode fields come combinationally from mem[rd_ptr] and are always driven, even when out_valid=0.
- Consumers must qualify every decode field with out_valid.
- flush clears rd_ptr, wr_ptr and count to 0.
  - flush overrides any same-cycle enqueue or dequeue; the incoming word is dropped.
  - Storage contents are not cleared by flush.
- Reset:
  - Pointers and count go to 0, and every mem entry goes to 16'h0000.
  - Resulting outputs: out_valid=0, in_ready=1, count=0, and all decode fields 0 (opcode = BR encoding 4'b0000).
- Reset asserted mid-operation discards all entries asynchronously; in-flight handshakes are lost.

## Timing
- All state is registered. There is no combinational path from `in` to the decode outputs (no empty bypass).
- Enqueue latency: a word accepted at edge N is visible on the decode outputs, with out_valid=1, after edge N. This holds when the queue was empty.
- Dequeue: after the edge where deq fires, the decode outputs show the next entry, or out_valid=0 if none remain.
- in_ready and out_valid depend only on registered count. No combinational dependence on in_valid or deq.
- Wrap-around: after DEPTH enqueues, wr_ptr returns to 0. FIFO order is preserved across the wrap.
- Sustained throughput is 1 enqueue + 1 dequeue per cycle whenever 0 < count < DEPTH.

## Structure
- lc3b_types already holds lc3b_word, lc3b_opcode, lc3b_reg and lc3b_offset6/9/11; reuse them unchanged.
- Pointer and count widths are local parameters derived from DEPTH; do not add them to the package.
- Sub-module ir_decode: purely combinational, takes lc3b_word in and produces the nine decode fields. The FIFO instantiates it once on mem[rd_ptr].
- ir_decode is reusable wherever a raw word must be split.

## Test plan
- Reset, then check idle: expect out_valid=0, in_ready=1, count=0, opcode=4'h0, offset11=11'h000.
- Fill and drain, DEPTH=4: push 16'h1242, 16'h5A3F, 16'hE1FF, 16'h0403.
  - After the 4th push: count=4, in_ready=0.
  - A 5th push while full is not accepted.
  - Dequeue ×4 and check decode per entry. 16'h1242 gives opcode=1, dest=1, src1=1, src2=2, imm5_enable=0. 16'h5A3F gives opcode=5, imm5_enable=1, offset6=6'h3F.
- Simultaneous enqueue + dequeue at count=2 for 10 cycles: count stays 2. Output order equals input order across pointer wrap.
- Flush with in_valid=1 and deq=1 at count=3: next cycle count=0, out_valid=0, and the pushed word never appears.
- Dequeue on empty: deq=1 for 3 cycles at count=0; pointers unchanged. A following push of 16'hB7C5 appears with opcode=4'hB and dest=3.
- Async reset mid-stream: assert reset between edges at count=3. Outputs go to reset values before the next edge, and the block operates normally after release.
